// File: rtl/cache_pkg.sv
// Shared types and derived geometry for the write-back cache controller.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WRITEBACK = 3'd2,
        REFILL    = 3'd3,
        FLUSH     = 3'd4
    } state_t;

    localparam int DEF_ADDR_WIDTH  = 12;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_INDEX_WIDTH = 4;

    function automatic int tag_width(input int addr_w, input int index_w);
        return addr_w - index_w;
    endfunction

    function automatic int num_lines(input int index_w);
        return 1 << index_w;
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/dirty/tag/data storage for a direct-mapped cache of one-word lines.
// Only valid and dirty are reset; tag/data contents are meaningless until valid.
module cache_line_store
    import cache_pkg::*;
#(
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int TAG_WIDTH   = DEF_ADDR_WIDTH - DEF_INDEX_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INDEX_WIDTH-1:0] rd_idx,
    output logic                   line_valid,
    output logic                   line_dirty,
    output logic [TAG_WIDTH-1:0]   line_tag,
    output logic [DATA_WIDTH-1:0]  line_data,
    input  logic [INDEX_WIDTH-1:0] wr_idx,
    input  logic                   set_valid,
    input  logic                   tag_we,
    input  logic                   data_we,
    input  logic                   dirty_set,
    input  logic                   dirty_clr,
    input  logic [TAG_WIDTH-1:0]   wr_tag,
    input  logic [DATA_WIDTH-1:0]  wr_data
);

    localparam int NUM_LINES = num_lines(INDEX_WIDTH);

    logic [NUM_LINES-1:0]  valid;
    logic [NUM_LINES-1:0]  dirty;
    logic [TAG_WIDTH-1:0]  tag_mem  [NUM_LINES];
    logic [DATA_WIDTH-1:0] data_mem [NUM_LINES];

    assign line_valid = valid[rd_idx];
    assign line_dirty = dirty[rd_idx];
    assign line_tag   = tag_mem[rd_idx];
    assign line_data  = data_mem[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (set_valid)
                valid[wr_idx] <= 1'b1;
            if (dirty_set)
                dirty[wr_idx] <= 1'b1;
            else if (dirty_clr)
                dirty[wr_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we)
            tag_mem[wr_idx] <= wr_tag;
        if (data_we)
            data_mem[wr_idx] <= wr_data;
    end

endmodule

// File: rtl/wb_cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller with one-word lines,
// sitting in front of a RAM with synchronous write and combinational read.
module wb_cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    input  logic                  flush_req,
    output logic                  flush_done,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam int TAG_WIDTH = tag_width(ADDR_WIDTH, INDEX_WIDTH);

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic                   we_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [INDEX_WIDTH-1:0] cnt;
    logic                   flush_pending;

    logic [INDEX_WIDTH-1:0] req_idx, line_idx;
    logic [TAG_WIDTH-1:0]   req_tag, line_tag;
    logic                   line_valid, line_dirty, hit;
    logic [DATA_WIDTH-1:0]  line_data, wr_data;
    logic                   set_valid, tag_we, data_we, dirty_set, dirty_clr;

    assign req_idx  = addr_q[INDEX_WIDTH-1:0];
    assign req_tag  = addr_q[ADDR_WIDTH-1:INDEX_WIDTH];
    assign line_idx = (state == FLUSH) ? cnt : req_idx;
    assign hit      = line_valid && (line_tag == req_tag);

    assign req_ready = (state == IDLE) && !flush_pending && !flush_req;

    // The store's read port always shows the line being worked on, so the
    // victim fields feed the RAM write port directly.
    assign mem_we    = (state == WRITEBACK) || (state == FLUSH && line_valid && line_dirty);
    assign mem_waddr = {line_tag, line_idx};
    assign mem_din   = line_data;
    assign mem_raddr = addr_q;

    assign wr_data = (state == REFILL && !we_q) ? mem_dout : wdata_q;

    always_comb begin
        set_valid = 1'b0;
        tag_we    = 1'b0;
        data_we   = 1'b0;
        dirty_set = 1'b0;
        dirty_clr = 1'b0;
        case (state)
            LOOKUP: begin
                data_we   = hit && we_q;
                dirty_set = hit && we_q;
            end
            WRITEBACK: dirty_clr = 1'b1;
            REFILL: begin
                set_valid = 1'b1;
                tag_we    = 1'b1;
                data_we   = 1'b1;
                dirty_set = we_q;
                dirty_clr = !we_q;
            end
            FLUSH:   dirty_clr = 1'b1;
            default: ;
        endcase
    end

    cache_line_store #(
        .INDEX_WIDTH(INDEX_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (line_idx),
        .line_valid(line_valid),
        .line_dirty(line_dirty),
        .line_tag  (line_tag),
        .line_data (line_data),
        .wr_idx    (line_idx),
        .set_valid (set_valid),
        .tag_we    (tag_we),
        .data_we   (data_we),
        .dirty_set (dirty_set),
        .dirty_clr (dirty_clr),
        .wr_tag    (req_tag),
        .wr_data   (wr_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr_q        <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            cnt           <= '0;
            flush_pending <= 1'b0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            flush_done    <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            flush_done <= 1'b0;
            if (flush_req && state != IDLE)
                flush_pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (flush_pending || flush_req) begin
                        state         <= FLUSH;
                        cnt           <= '0;
                        flush_pending <= 1'b0;
                    end else if (req_valid && req_ready) begin
                        addr_q  <= req_addr;
                        we_q    <= req_we;
                        wdata_q <= req_wdata;
                        state   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (!we_q)
                            resp_rdata <= line_data;
                        resp_valid <= 1'b1;
                        state      <= IDLE;
                    end else if (line_valid && line_dirty) begin
                        state <= WRITEBACK;
                    end else begin
                        state <= REFILL;
                    end
                end
                WRITEBACK: state <= REFILL;
                REFILL: begin
                    if (!we_q)
                        resp_rdata <= mem_dout;
                    resp_valid <= 1'b1;
                    state      <= IDLE;
                end
                FLUSH: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        state      <= IDLE;
                        flush_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cache_ctrl.sv
// Bench for wb_cache_ctrl: transaction-level cache/RAM model predicts per-cycle
// responses and RAM writes; directed scenarios plus randomized traffic.
module tb_wb_cache_ctrl;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NL = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          flush_req = 1'b0;
    logic          flush_done;
    logic          mem_we;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [DW-1:0] mem_din, mem_dout;

    always #5 clk = ~clk;

    wb_cache_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INDEX_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .flush_req(flush_req), .flush_done(flush_done),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_din(mem_din),
        .mem_raddr(mem_raddr), .mem_dout(mem_dout)
    );

    // backing RAM: synchronous write, combinational read
    logic [DW-1:0] ram     [0:(1<<AW)-1];
    logic [DW-1:0] ram_exp [0:(1<<AW)-1];
    always @(posedge clk) if (mem_we) ram[mem_waddr] <= mem_din;
    assign mem_dout = ram[mem_raddr];

    // model: cache contents plus expected events keyed by cycle number
    bit            mv [NL];
    bit            md [NL];
    logic [7:0]    mt [NL];
    logic [DW-1:0] mdat [NL];
    logic [DW:0]      exp_resp [int];
    logic [AW+DW-1:0] exp_we   [int];
    bit               exp_fd   [int];

    int cyc = 0;
    int busy_until = 0;
    int n_cmp = 0, n_bad = 0;
    logic [DW-1:0] last_rdata = '0;
    int we_count = 0, last_resp_cyc = -1, last_fd_cyc = -1;
    int last_acc = 0, last_f = 0, last_lat = 0;
    logic [AW-1:0] last_wa = '0;
    logic [DW-1:0] last_wd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // expected RAM image follows the writes the model predicts for this edge
    always @(posedge clk)
        if (rst_n && exp_we.exists(cyc))
            ram_exp[exp_we[cyc][AW+DW-1:DW]] = exp_we[cyc][DW-1:0];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        #1;
        chk("req_ready", 64'(req_ready), 64'(cyc >= busy_until && !flush_req));
        chk("resp_valid", 64'(resp_valid), 64'(exp_resp.exists(cyc)));
        if (resp_valid) last_resp_cyc = cyc;
        if (exp_resp.exists(cyc) && exp_resp[cyc][DW]) last_rdata = exp_resp[cyc][DW-1:0];
        chk("resp_rdata", 64'(resp_rdata), 64'(last_rdata));
        chk("mem_we", 64'(mem_we), 64'(exp_we.exists(cyc)));
        if (mem_we) begin
            we_count++;
            last_wa = mem_waddr;
            last_wd = mem_din;
        end
        if (mem_we && exp_we.exists(cyc)) begin
            chk("mem_waddr", 64'(mem_waddr), 64'(exp_we[cyc][AW+DW-1:DW]));
            chk("mem_din", 64'(mem_din), 64'(exp_we[cyc][DW-1:0]));
        end
        chk("flush_done", 64'(flush_done), 64'(exp_fd.exists(cyc)));
        if (flush_done) last_fd_cyc = cyc;
        chk("resp_and_done", 64'(resp_valid & flush_done), 64'(0));
    end

    task automatic model_flush(input int f);
        for (int j = 0; j < NL; j++)
            if (mv[j] && md[j]) begin
                exp_we[f + j] = {mt[j], 4'(j), mdat[j]};
                md[j] = 1'b0;
            end
        exp_fd[f + NL] = 1'b1;
        busy_until = f + NL;
        last_f = f;
    endtask

    task automatic model_reset();
        for (int j = 0; j < NL; j++) begin
            mv[j] = 1'b0;
            md[j] = 1'b0;
        end
        exp_resp.delete();
        exp_we.delete();
        exp_fd.delete();
        last_rdata = '0;
        busy_until = cyc;
    endtask

    task automatic summary_and_die(input string why);
        n_bad++;
        $display("FAIL %s: bound expired (cycle %0d)", why, cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "bench aborted");
    endtask

    // mode 0 plain, 1 flush in the same cycle, 2 flush while busy, 3 reset mid-writeback
    task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input int mode);
        int waited, a, lat;
        logic [3:0] idx;
        logic [7:0] tg;
        logic [DW-1:0] rd;
        waited = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        if (mode == 1) begin
            flush_req = 1'b1;
            model_flush(cyc + 1);
            @(negedge clk);
            flush_req = 1'b0;
        end
        #2;
        while (!req_ready) begin
            @(negedge clk);
            #2;
            waited++;
            if (waited > 200) summary_and_die("req_accept");
        end
        a   = cyc + 1;
        idx = addr[3:0];
        tg  = addr[11:4];
        rd  = mdat[idx];
        if (mv[idx] && mt[idx] == tg) begin
            lat = 1;
            if (we) begin
                mdat[idx] = wd;
                md[idx]   = 1'b1;
            end
        end else begin
            lat = 2;
            if (mv[idx] && md[idx]) begin
                exp_we[a + 1] = {mt[idx], idx, mdat[idx]};
                lat = 3;
            end
            rd        = ram_exp[addr];
            mv[idx]   = 1'b1;
            mt[idx]   = tg;
            md[idx]   = we;
            mdat[idx] = we ? wd : rd;
        end
        exp_resp[a + lat] = {!we, rd};
        busy_until = a + lat;
        last_acc = a;
        last_lat = lat;
        @(negedge clk);
        req_valid = 1'b0;
        if (mode == 2) begin
            flush_req = 1'b1;
            model_flush(a + lat + 1);
            @(negedge clk);
            flush_req = 1'b0;
            if (lat == 3) begin
                @(negedge clk);
                flush_req = 1'b1;
                @(negedge clk);
                flush_req = 1'b0;
            end
        end
        if (mode == 3 && lat == 3) begin
            @(negedge clk);
            #2;
            chk("wb_active_before_reset", 64'(mem_we), 64'(1));
            rst_n = 1'b0;
            model_reset();
            #1;
            chk("reset_mem_we", 64'(mem_we), 64'(0));
            chk("reset_resp_valid", 64'(resp_valid), 64'(0));
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
        end
        while (cyc < busy_until - 1) @(negedge clk);
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush_req = 1'b1;
        model_flush(cyc + 1);
        @(negedge clk);
        flush_req = 1'b0;
        while (cyc < busy_until - 1) @(negedge clk);
    endtask

    task automatic settle();
        @(negedge clk);
        #3;
    endtask

    int we0, r, bad_words;
    logic [AW-1:0] ra;

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = $urandom;
        ram['h013] = 32'hDEADBEEF;
        ram['h023] = 32'hCAFEF00D;
        ram['h045] = 32'h0BADC0DE;
        for (int i = 0; i < (1 << AW); i++) ram_exp[i] = ram[i];
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_resp_rdata", 64'(resp_rdata), 64'(0));
        chk("rst_flush_done", 64'(flush_done), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // 1: refill then hit
        we0 = we_count;
        do_req(1'b0, 12'h013, '0, 0); settle();
        chk("t1_rdata", 64'(resp_rdata), 64'h0DEADBEEF);
        chk("t1_miss_lat", 64'(last_resp_cyc - last_acc), 64'(2));
        chk("t1_no_we", 64'(we_count - we0), 64'(0));
        do_req(1'b0, 12'h013, '0, 0); settle();
        chk("t1_hit_lat", 64'(last_resp_cyc - last_acc), 64'(1));
        chk("t1_hit_rdata", 64'(resp_rdata), 64'h0DEADBEEF);

        // 2: dirty victim written back before refill
        do_req(1'b1, 12'h013, 32'h11112222, 0); settle();
        chk("t2_whit_lat", 64'(last_resp_cyc - last_acc), 64'(1));
        we0 = we_count;
        do_req(1'b0, 12'h023, '0, 0); settle();
        chk("t2_wb_count", 64'(we_count - we0), 64'(1));
        chk("t2_wb_addr", 64'(last_wa), 64'h013);
        chk("t2_wb_data", 64'(last_wd), 64'h11112222);
        chk("t2_lat", 64'(last_resp_cyc - last_acc), 64'(3));
        chk("t2_rdata", 64'(resp_rdata), 64'hCAFEF00D);
        chk("t2_ram", 64'(ram['h013]), 64'h11112222);

        // 3: write-allocate miss on a clean index
        we0 = we_count;
        do_req(1'b1, 12'h045, 32'hA5A5A5A5, 0); settle();
        chk("t3_no_we", 64'(we_count - we0), 64'(0));
        chk("t3_lat", 64'(last_resp_cyc - last_acc), 64'(2));
        do_req(1'b0, 12'h045, '0, 0); settle();
        chk("t3_rdata", 64'(resp_rdata), 64'hA5A5A5A5);
        chk("t3_ram_old", 64'(ram['h045]), 64'h0BADC0DE);

        // 4: flush with dirty lines at idx 3 and 5
        do_req(1'b1, 12'h023, 32'h33334444, 0); settle();
        we0 = we_count;
        do_flush(); settle();
        chk("t4_we_count", 64'(we_count - we0), 64'(2));
        chk("t4_done_time", 64'(last_fd_cyc - last_f), 64'(16));
        chk("t4_ram3", 64'(ram['h023]), 64'h33334444);
        chk("t4_ram5", 64'(ram['h045]), 64'hA5A5A5A5);
        we0 = we_count;
        do_req(1'b0, 12'h023, '0, 0); settle();
        chk("t4_no_wb", 64'(we_count - we0), 64'(0));
        chk("t4_rdata", 64'(resp_rdata), 64'h33334444);

        // 5: reset during a writeback abandons it
        do_req(1'b1, 12'h013, 32'h55556666, 0); settle();
        do_req(1'b0, 12'h033, '0, 3); settle();
        chk("t5_resp_after_rst", 64'(resp_valid), 64'(0));
        do_req(1'b0, 12'h013, '0, 0); settle();
        chk("t5_miss_lat", 64'(last_resp_cyc - last_acc), 64'(2));
        chk("t5_rdata", 64'(resp_rdata), 64'h11112222);

        // 6: flush and request in the same idle cycle
        do_req(1'b1, 12'h045, 32'h77778888, 0); settle();
        do_req(1'b0, 12'h045, '0, 1); settle();
        chk("t6_accept_time", 64'(last_acc - last_f), 64'(17));
        chk("t6_done_time", 64'(last_fd_cyc - last_f), 64'(16));
        chk("t6_rdata", 64'(resp_rdata), 64'h77778888);
        chk("t6_ram", 64'(ram['h045]), 64'h77778888);

        // randomized back-to-back traffic over a few tags per index
        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 99);
            ra = {6'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            if (r < 8)
                do_flush();
            else
                do_req(1'($urandom_range(0, 1)), ra, $urandom,
                       (r < 16) ? 2 : ((r < 22) ? 1 : 0));
        end

        do_flush();
        repeat (3) @(negedge clk);
        #3;
        bad_words = 0;
        for (int i = 0; i < (1 << AW); i++)
            if (ram[i] !== ram_exp[i]) bad_words++;
        chk("ram_image", 64'(bad_words), 64'(0));
        for (int j = 0; j < NL; j++)
            if (mv[j]) chk("line_in_ram", 64'(ram[{mt[j], 4'(j)}]), 64'(mdat[j]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
